// File: rtl/fw_hazard_unit_pkg.sv
// rtl/fw_hazard_unit_pkg.sv - shared types, defaults and helpers for the forwarding/hazard unit
package fw_hazard_unit_pkg;

  localparam int NUM_SRC_DEF    = 2;
  localparam int FW_DEPTH_DEF   = 2;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int SEL_W_DEF      = $clog2(FW_DEPTH_DEF + 1);
  localparam int STG_W_DEF      = SEL_W_DEF;

  typedef logic [SEL_W_DEF-1:0] fw_sel_t;

  localparam fw_sel_t FW_SEL_REGFILE = '0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [STG_W_DEF-1:0]      rdy_stage;
  } fw_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Out-of-range ready stages are pessimistically pushed to the last stage.
  function automatic int norm_rdy(input int stg, input int depth);
    return (stg < 1 || stg > depth) ? depth : stg;
  endfunction

endpackage

// File: rtl/fw_match.sv
// rtl/fw_match.sv - youngest-first producer matcher for one source operand
module fw_match
  import fw_hazard_unit_pkg::*;
#(
  parameter int FW_DEPTH   = 2,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                           used,
  input  logic [REG_ADDR_W-1:0]          addr,
  input  logic [FW_DEPTH-1:0]            trk_valid,
  input  logic [FW_DEPTH*REG_ADDR_W-1:0] trk_rd,
  input  logic [FW_DEPTH*SEL_W-1:0]      trk_rdy,
  output logic [SEL_W-1:0]               sel,
  output logic                           hazard
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel    = SEL_W'(FW_SEL_REGFILE);
    hazard = 1'b0;
    if (used && addr != '0) begin
      for (int j = FW_DEPTH - 1; j >= 0; j--) begin
        if (trk_valid[j] && trk_rd[j*REG_ADDR_W +: REG_ADDR_W] == addr) begin
          if (trk_rdy[j*SEL_W +: SEL_W] <= SEL_W'(j + 1)) begin
            sel    = SEL_W'(j + 1);
            hazard = 1'b0;
          end else begin
            sel    = SEL_W'(FW_SEL_REGFILE);
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fw_hazard_unit.sv
// rtl/fw_hazard_unit.sv - in-flight write tracker, per-source forward select and load-use stall
module fw_hazard_unit
  import fw_hazard_unit_pkg::*;
#(
  parameter int  NUM_SRC    = NUM_SRC_DEF,
  parameter int  FW_DEPTH   = FW_DEPTH_DEF,
  parameter int  REG_ADDR_W = REG_ADDR_W_DEF,
  localparam int SEL_W      = sel_width(FW_DEPTH),
  localparam int STG_W      = SEL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_rd_we,
  input  logic [STG_W-1:0]              id_rdy_stage,
  output logic                          id_ready,
  input  logic                          pipe_freeze,
  input  logic                          ex_flush,
  output logic                          ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]      ex_src_sel
);

  logic [FW_DEPTH-1:0]            trk_valid;
  logic [FW_DEPTH*REG_ADDR_W-1:0] trk_rd;
  logic [FW_DEPTH*STG_W-1:0]      trk_rdy;
  logic [NUM_SRC-1:0]             src_haz;
  logic [NUM_SRC*SEL_W-1:0]       src_sel;
  logic                           hazard;
  logic                           accept;
  logic                           id_we_eff;
  logic [STG_W-1:0]               rdy_norm;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fw_match #(
      .FW_DEPTH   (FW_DEPTH),
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
    ) u_match (
      .used      (id_src_used[s]),
      .addr      (id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
      .trk_valid (trk_valid),
      .trk_rd    (trk_rd),
      .trk_rdy   (trk_rdy),
      .sel       (src_sel[s*SEL_W +: SEL_W]),
      .hazard    (src_haz[s])
    );
  end

  assign hazard    = id_valid & (|src_haz);
  assign id_ready  = !pipe_freeze && !hazard;
  assign accept    = id_valid && !hazard && !ex_flush;
  assign id_we_eff = id_rd_we && (id_rd_addr != '0);
  assign rdy_norm  = STG_W'(norm_rdy(int'(id_rdy_stage), FW_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid  <= '0;
      trk_rd     <= '0;
      trk_rdy    <= '0;
      ex_valid   <= 1'b0;
      ex_src_sel <= '0;
    end else if (!pipe_freeze) begin
      // A flush kills the EX instruction as it moves into stage 1.
      for (int k = FW_DEPTH - 1; k >= 1; k--) begin
        trk_valid[k]                        <= trk_valid[k-1] && !(k == 1 && ex_flush);
        trk_rd[k*REG_ADDR_W +: REG_ADDR_W]  <= trk_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W];
        trk_rdy[k*STG_W +: STG_W]           <= trk_rdy[(k-1)*STG_W +: STG_W];
      end
      if (accept) begin
        trk_valid[0]            <= id_we_eff;
        trk_rd[0 +: REG_ADDR_W] <= id_rd_addr;
        trk_rdy[0 +: STG_W]     <= rdy_norm;
        ex_valid                <= 1'b1;
        ex_src_sel              <= src_sel;
      end else begin
        trk_valid[0] <= 1'b0;
        ex_valid     <= 1'b0;
        ex_src_sel   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fw_hazard_unit.sv
// tb/tb_fw_hazard_unit.sv - scoreboard bench for fw_hazard_unit
module tb_fw_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_src_addr;
  logic [1:0] id_src_used;
  logic [4:0] id_rd_addr;
  logic       id_rd_we;
  logic [1:0] id_rdy_stage;
  logic       id_ready;
  logic       pipe_freeze;
  logic       ex_flush;
  logic       ex_valid;
  logic [3:0] ex_src_sel;

  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] u;
    logic [4:0] rd;
    logic       we;
    logic [1:0] rdy;
    logic       fl;
    logic       fz;
    logic       erdy;
    logic       eexv;
    logic [1:0] e0;
    logic [1:0] e1;
  } row_t;

  typedef struct {
    logic       exv;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fw_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_addr  (id_src_addr),
    .id_src_used  (id_src_used),
    .id_rd_addr   (id_rd_addr),
    .id_rd_we     (id_rd_we),
    .id_rdy_stage (id_rdy_stage),
    .id_ready     (id_ready),
    .pipe_freeze  (pipe_freeze),
    .ex_flush     (ex_flush),
    .ex_valid     (ex_valid),
    .ex_src_sel   (ex_src_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic row_t mk(input int v, input int s0, input int s1, input int u,
                              input int rd, input int we, input int rdy, input int fl,
                              input int fz, input int erdy, input int eexv,
                              input int e0, input int e1);
    row_t r;
    r.v = 1'(v);   r.s0 = 5'(s0); r.s1 = 5'(s1); r.u = 2'(u);
    r.rd = 5'(rd); r.we = 1'(we); r.rdy = 2'(rdy); r.fl = 1'(fl); r.fz = 1'(fz);
    r.erdy = 1'(erdy); r.eexv = 1'(eexv); r.e0 = 2'(e0); r.e1 = 2'(e1);
    return r;
  endfunction

  function automatic row_t idle();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
  endfunction

  task automatic apply(input row_t r);
    id_valid     = r.v;
    id_src_addr  = {r.s1, r.s0};
    id_src_used  = r.u;
    id_rd_addr   = r.rd;
    id_rd_we     = r.we;
    id_rdy_stage = r.rdy;
    ex_flush     = r.fl;
    pipe_freeze  = r.fz;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(idle());
    #3;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_src_sel !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b sel=%h want v=0 sel=0", ex_valid, ex_src_sel);
    end
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1", id_ready);
    end
    pipe_freeze = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_frozen got %b want 0", id_ready);
    end
    pipe_freeze = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_chain();
    row_t t[$];
    exp_t e;
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 3, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0));
    t.push_back(mk(1, 0, 3, 2, 0, 0, 1, 0, 0, 1, 1, 0, 2));
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_checks++;
      if (id_ready !== t[i].erdy) begin
        n_fail++;
        $display("FAIL alu_chain[%0d] id_ready got %b want %b", i, id_ready, t[i].erdy);
      end
      sb.push_back('{t[i].eexv, {t[i].e1, t[i].e0}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
        n_fail++;
        $display("FAIL alu_chain[%0d] ex got v=%b sel=%h want v=%b sel=%h",
                 i, ex_valid, ex_src_sel, e.exv, e.sel);
      end
    end
  endtask

  task automatic test_load_use();
    row_t t[$];
    exp_t e;
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 0, 0, 0, 4, 1, 2, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 4, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 4, 2, 0, 0, 1, 0, 0, 1, 1, 0, 2));
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_checks++;
      if (id_ready !== t[i].erdy) begin
        n_fail++;
        $display("FAIL load_use[%0d] id_ready got %b want %b", i, id_ready, t[i].erdy);
      end
      sb.push_back('{t[i].eexv, {t[i].e1, t[i].e0}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
        n_fail++;
        $display("FAIL load_use[%0d] ex got v=%b sel=%h want v=%b sel=%h",
                 i, ex_valid, ex_src_sel, e.exv, e.sel);
      end
    end
  endtask

  task automatic test_youngest_and_boundary();
    row_t t[$];
    exp_t e;
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 5, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0));
    t.push_back(mk(1, 0, 0, 0, 11, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 12, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 11, 12, 3, 0, 0, 1, 0, 0, 1, 1, 2, 1));
    t.push_back(mk(1, 0, 0, 0, 13, 1, 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 13, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 13, 0, 1, 0, 0, 1, 0, 0, 1, 1, 2, 0));
    t.push_back(mk(1, 0, 0, 0, 16, 1, 3, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 16, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 16, 2, 0, 0, 1, 0, 0, 1, 1, 0, 2));
    t.push_back(mk(1, 0, 0, 0, 7, 1, 2, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 7, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 8, 0, 2, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 8, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_checks++;
      if (id_ready !== t[i].erdy) begin
        n_fail++;
        $display("FAIL young_bound[%0d] id_ready got %b want %b", i, id_ready, t[i].erdy);
      end
      sb.push_back('{t[i].eexv, {t[i].e1, t[i].e0}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
        n_fail++;
        $display("FAIL young_bound[%0d] ex got v=%b sel=%h want v=%b sel=%h",
                 i, ex_valid, ex_src_sel, e.exv, e.sel);
      end
    end
  endtask

  task automatic test_flush();
    row_t t[$];
    exp_t e;
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 0, 0, 0, 6, 1, 2, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 14, 1, 1, 1, 0, 1, 0, 0, 0));
    t.push_back(mk(1, 6, 14, 3, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_checks++;
      if (id_ready !== t[i].erdy) begin
        n_fail++;
        $display("FAIL flush[%0d] id_ready got %b want %b", i, id_ready, t[i].erdy);
      end
      sb.push_back('{t[i].eexv, {t[i].e1, t[i].e0}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
        n_fail++;
        $display("FAIL flush[%0d] ex got v=%b sel=%h want v=%b sel=%h",
                 i, ex_valid, ex_src_sel, e.exv, e.sel);
      end
    end
  endtask

  task automatic test_freeze_reset();
    row_t t[$];
    exp_t e;
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 0, 0, 0, 10, 1, 1, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 10, 0, 1, 9, 1, 2, 0, 0, 1, 1, 1, 0));
    t.push_back(mk(1, 9, 0, 1, 15, 1, 2, 0, 1, 0, 1, 1, 0));
    t.push_back(mk(1, 9, 0, 1, 15, 1, 2, 1, 1, 0, 1, 1, 0));
    t.push_back(mk(1, 9, 0, 1, 15, 1, 2, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 9, 0, 1, 15, 1, 2, 0, 0, 1, 1, 2, 0));
    foreach (t[i]) begin
      apply(t[i]);
      #1;
      n_checks++;
      if (id_ready !== t[i].erdy) begin
        n_fail++;
        $display("FAIL freeze[%0d] id_ready got %b want %b", i, id_ready, t[i].erdy);
      end
      sb.push_back('{t[i].eexv, {t[i].e1, t[i].e0}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
        n_fail++;
        $display("FAIL freeze[%0d] ex got v=%b sel=%h want v=%b sel=%h",
                 i, ex_valid, ex_src_sel, e.exv, e.sel);
      end
    end
    // Asynchronous reset mid-cycle while a load to r15 sits in ID/EX.
    apply(idle());
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_src_sel !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs got v=%b sel=%h want v=0 sel=0", ex_valid, ex_src_sel);
    end
    pipe_freeze = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready_frozen got %b want 0", id_ready);
    end
    pipe_freeze = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(1, 15, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL postreset_ready got %b want 1", id_ready);
    end
    sb.push_back('{1'b1, 4'h0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (ex_valid !== e.exv || ex_src_sel !== e.sel) begin
      n_fail++;
      $display("FAIL postreset_ex got v=%b sel=%h want v=%b sel=%h",
               ex_valid, ex_src_sel, e.exv, e.sel);
    end
    apply(idle());
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest_and_boundary();
    test_flush();
    test_freeze_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
